// File: rtl/ps2_barcode_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_barcode_rx
// Description : PS/2 keyboard-wedge receiver for the barcode scanner. Decodes
//               digit and Enter make codes and assembles a 13-digit ASCII
//               ticket code into ps2_register. ps2_key1 is a level that stays
//               high while a complete code is held, until scan_clr or rst.
//               Optional feature macro: PS2_KEYPAD_EN (numeric keypad digits
//               and keypad Enter E0 5A are also accepted).
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_barcode_rx #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    input  logic         scan_clr,
    output logic [103:0] ps2_register,
    output logic         ps2_key1,
    output logic [3:0]   digit_cnt,
    output logic         frame_err,
    output logic         len_err
);

    localparam int                c_TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] c_CODE_BREAK = 8'hF0;
    localparam logic [7:0] c_CODE_EXT   = 8'hE0;
    localparam logic [7:0] c_CODE_ENTER = 8'h5A;
    localparam logic [3:0] c_FULL_CNT   = 4'd13;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_break     = 2'd1;
    localparam logic [1:0] c_st_ext       = 2'd2;
    localparam logic [1:0] c_st_ext_break = 2'd3;

    // synchronizers and falling-edge history
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    // frame receiver
    logic [3:0]        r_bit_cnt;
    logic [10:0]       r_shift;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_frame_done;

    // byte check / decode
    logic [7:0] w_data;
    logic       w_frame_ok;
    logic       w_byte_vld;
    logic       w_byte_bad;
    logic       w_is_digit;
    logic [7:0] w_ascii;
    logic       w_enter_ext;
    logic       w_do_digit;
    logic       w_do_enter;

    // decoder state and registered outputs
    logic [1:0]   r_state;
    logic [103:0] r_reg;
    logic         r_key;
    logic [3:0]   r_cnt;
    logic         r_frame_err;
    logic         r_len_err;

    // Two-flop synchronizers on the asynchronous PS/2 pins, plus one extra
    // stage of clock history for falling-edge detection (idle level is 1).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;

    // Shift in one bit per falling edge; flag a complete 11-bit frame and
    // drop a stalled partial frame once the idle timeout expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt    <= 4'd0;
            r_shift      <= 11'd0;
            r_to_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_fall) begin
                // LSB-first frame: after 11 shifts start sits in [0], stop in [10]
                r_shift  <= {r_dat_s2, r_shift[10:1]};
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt    <= 4'd0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == c_TO_LAST) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_TO_W'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    // Frame is good when start=0, odd parity over data+parity, stop=1.
    assign w_data     = r_shift[8:1];
    assign w_frame_ok = ~r_shift[0] & (^r_shift[9:1]) & r_shift[10];
    assign w_byte_vld = r_frame_done & w_frame_ok;
    assign w_byte_bad = r_frame_done & ~w_frame_ok;

    // Map make codes to ASCII digits.
    always_comb begin
        w_is_digit = 1'b1;
        w_ascii    = 8'h00;
        case (w_data)
            8'h45: w_ascii = 8'h30;
            8'h16: w_ascii = 8'h31;
            8'h1E: w_ascii = 8'h32;
            8'h26: w_ascii = 8'h33;
            8'h25: w_ascii = 8'h34;
            8'h2E: w_ascii = 8'h35;
            8'h36: w_ascii = 8'h36;
            8'h3D: w_ascii = 8'h37;
            8'h3E: w_ascii = 8'h38;
            8'h46: w_ascii = 8'h39;
`ifdef PS2_KEYPAD_EN
            8'h70: w_ascii = 8'h30;
            8'h69: w_ascii = 8'h31;
            8'h72: w_ascii = 8'h32;
            8'h7A: w_ascii = 8'h33;
            8'h6B: w_ascii = 8'h34;
            8'h73: w_ascii = 8'h35;
            8'h74: w_ascii = 8'h36;
            8'h6C: w_ascii = 8'h37;
            8'h75: w_ascii = 8'h38;
            8'h7D: w_ascii = 8'h39;
`endif
            default: w_is_digit = 1'b0;
        endcase
    end

`ifdef PS2_KEYPAD_EN
    // keypad Enter arrives as E0 5A
    assign w_enter_ext = (r_state == c_st_ext);
`else
    assign w_enter_ext = 1'b0;
`endif

    assign w_do_digit = w_byte_vld & (r_state == c_st_idle) & w_is_digit;
    assign w_do_enter = w_byte_vld & (w_data == c_CODE_ENTER) &
                        ((r_state == c_st_idle) | w_enter_ext);

    // Prefix-tracking decoder plus the code register, key level and error
    // pulses; scan_clr beats a same-cycle digit/Enter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_reg       <= 104'd0;
            r_key       <= 1'b0;
            r_cnt       <= 4'd0;
            r_frame_err <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_frame_err <= w_byte_bad;
            r_len_err   <= 1'b0;

            if (w_byte_vld) begin
                case (r_state)
                    c_st_idle: begin
                        if (w_data == c_CODE_BREAK)
                            r_state <= c_st_break;
                        else if (w_data == c_CODE_EXT)
                            r_state <= c_st_ext;
                    end
                    c_st_ext: begin
                        if (w_data == c_CODE_BREAK)
                            r_state <= c_st_ext_break;
                        else
                            r_state <= c_st_idle;
                    end
                    default: r_state <= c_st_idle;
                endcase
            end

            if (scan_clr) begin
                r_key <= 1'b0;
                r_reg <= 104'd0;
                r_cnt <= 4'd0;
            end else if (!r_key) begin
                if (w_do_digit) begin
                    r_reg <= {r_reg[95:0], w_ascii};
                    if (r_cnt != c_FULL_CNT)
                        r_cnt <= r_cnt + 4'd1;
                end else if (w_do_enter) begin
                    if (r_cnt == c_FULL_CNT) begin
                        r_key <= 1'b1;
                    end else begin
                        r_len_err <= 1'b1;
                        r_reg     <= 104'd0;
                        r_cnt     <= 4'd0;
                    end
                end
            end
        end
    end

    assign ps2_register = r_reg;
    assign ps2_key1     = r_key;
    assign digit_cnt    = r_cnt;
    assign frame_err    = r_frame_err;
    assign len_err      = r_len_err;

endmodule
`default_nettype wire

// File: doc/ps2_barcode_rx.md
# ps2_barcode_rx

Receives the PS/2 keyboard-wedge stream from the parking-lot barcode scanner, decodes make codes for digits and Enter, and assembles the 13-digit ticket code as ASCII into `ps2_register[103:0]`. It sits directly upstream of the location/address translation stage. `ps2_key1` is asserted as a level while a complete, valid 13-digit code is held. The downstream stage reads `ps2_register` whenever `ps2_key1` is high.

## Interface
- `TIMEOUT_CYC`, 50000: idle `clk` cycles mid-frame after which a partial PS/2 frame is discarded (1 ms at 50 MHz).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `ps2_clk`  in  1  PS/2 clock from the scanner; asynchronous, open-drain, idle high.
- `ps2_data`  in  1  PS/2 data from the scanner; asynchronous.
- `scan_clr`  in  1  one-cycle pulse from the controller; consumes the held code.
- `ps2_register`  out  104  13 ASCII digits; the first-scanned digit is in [103:96] and the last is in [7:0].
- `ps2_key1`  out  1  level; high while a valid 13-digit code is held.
- `digit_cnt`  out  4  number of digits collected so far (0–13).
- `frame_err`  out  1  one-cycle pulse on a bad start, parity, or stop bit.
- `len_err`  out  1  one-cycle pulse when Enter arrives with `digit_cnt` ≠ 13.

## Operation
- **Input sync:** `ps2_clk` and `ps2_data` each pass through 2 flip-flops. A falling edge is detected when the synchronized clock's previous value is 1 and its current value is 0.
- **Frame format:** 11 bits, sampled on falling edges: start (0), 8 data bits LSB first, odd parity, stop (1).
  - A 4-bit bit counter runs 0–10.
  - After bit 10, the byte is accepted only if start = 0, parity is odd over data+parity, and stop = 1. Otherwise `frame_err` pulses and the byte is dropped.
- **Timeout:** if the bit counter is nonzero and no falling edge arrives for `TIMEOUT_CYC` cycles, the bit counter returns to 0 with no error pulse.
- **Decoder FSM states:** IDLE, BREAK, EXT, EXT_BREAK.
  - IDLE:
    - 0xF0 → BREAK.
    - 0xE0 → EXT.
    - A digit make code → digit action.
    - 0x5A → enter action.
    - Any other byte → ignored.
  - BREAK: the next byte is discarded → IDLE.
  - EXT:
    - 0xF0 → EXT_BREAK.
    - 0x5A → enter action (only with the macro; see Configuration).
    - Anything else → ignored.
    - Always returns to IDLE except on 0xF0.
  - EXT_BREAK: the next byte is discarded → IDLE.
- **Digit make codes:** 45='0', 16='1', 1E='2', 26='3', 25='4', 2E='5', 36='6', 3D='7', 3E='8', 46='9'. Each maps to ASCII 0x30–0x39.
- **Digit action** (ignored while `ps2_key1`=1):
  - `ps2_register <= {ps2_register[95:0], ascii}`.
  - `digit_cnt` increments and saturates at 13. Beyond 13 digits, the register keeps the last 13.
- **Enter action** (ignored while `ps2_key1`=1):
  - If `digit_cnt`=13: `ps2_key1 <= 1`, and the register is frozen.
  - Otherwise: `len_err` pulses, and `ps2_register` and `digit_cnt` clear to 0.
- **scan_clr:** clears `ps2_key1`, `ps2_register`, and `digit_cnt` to 0. It does not affect the frame receiver or the decoder FSM.

## Timing
- **Reset values:** `ps2_register`=0, `ps2_key1`=0, `digit_cnt`=0, `frame_err`=0, `len_err`=0. Bit counter=0, timeout counter=0, FSM=IDLE.
- **Latency:**
  - Edge-detect cycle N: the 11th falling edge is detected.
  - N+1: the byte is checked and decoded.
  - N+2: `ps2_register`, `digit_cnt`, `ps2_key1`, and the error pulses update.
- **Pin latency:** from the `ps2_clk` pin falling to edge detection is 3 cycles.
- **Simultaneous events:**
  - `scan_clr` in the same cycle as a digit or Enter update: `scan_clr` wins, and the byte is dropped.
  - `rst` overrides everything.
- **Reset mid-frame:** the partial frame is lost. The remaining bits are treated as a new frame, which yields `frame_err` or a bad byte. The timeout then resynchronizes the receiver.
- **Output shape:** `ps2_key1` is a level, held indefinitely until `scan_clr` or `rst`. The error outputs are exactly 1 cycle wide.

## Configuration
- **`PS2_KEYPAD_EN` defined:**
  - Numeric keypad make codes are also digits: 70='0', 69='1', 72='2', 7A='3', 6B='4', 73='5', 74='6', 6C='7', 75='8', 7D='9'.
  - Keypad Enter (E0 5A) performs the enter action.
- **`PS2_KEYPAD_EN` undefined:**
  - Keypad codes are ignored in IDLE.
  - E0 5A is ignored.

## Test plan
- Send the frames for "9787358975290" then 5A, with break codes interleaved → `ps2_register`=104'h39_37_38_37_33_35_38_39_37_35_32_39_30. `ps2_key1`=1 at N+2 after the Enter byte, and `digit_cnt`=13.
- With `ps2_key1` held, send digit 16 and then 5A → register unchanged, no error pulse. Then pulse `scan_clr` → all outputs 0 the next cycle.
- Send 5 digits then 5A → 1-cycle `len_err`, `digit_cnt`=0, `ps2_register`=0. Send 14 digits "1"–"9","0","1","2","3","4" then 5A → register holds the last 13 digits (first "2" … last "4").
- Send one byte with wrong parity, and one with stop=0 → each gives one `frame_err` pulse and no register change. Stop `ps2_clk` after 5 bits for > `TIMEOUT_CYC` cycles, then send valid 45 → `digit_cnt`=1, `ps2_register[7:0]`=0x30.
- Send F0 45 then E0 F0 5A → no register change.
  - With `PS2_KEYPAD_EN`: send 13 keypad digits then E0 5A → `ps2_key1`=1.
  - Without `PS2_KEYPAD_EN`: the same sequence gives `digit_cnt`=0 and `ps2_key1`=0.
- Assert `scan_clr` in the same cycle as the valid Enter update → `ps2_key1` stays 0 and the register clears. Assert `rst` mid-frame → all outputs 0 the next cycle.
